cache_req_arbiter: RTL and testbench

// Shares the single cache controller/memory datapath between NUM_REQ requesters (OBI front-end, maintenance agents).
// - Grants one request at a time, round-robin.
// - Forwards the request to the controller with a valid/ready handshake and waits for completion.
// - Routes the hit flag and read data back to the owning requester.
// - Sits between the requester interfaces and the controller/memory pair; at most one operation is outstanding.

---
 rtl/cache_req_arbiter.sv | 159 +++++++++++++++
 tb/tb_cache_req_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter sharing one cache controller among NUM_REQ requesters, one op in flight.
// Optional WAIT timeout with error response: define CACHE_ARB_TIMEOUT_EN.
module cache_req_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int KEY_WIDTH      = 16,
    parameter int VALUE_WIDTH    = 64,
`ifdef CACHE_ARB_TIMEOUT_EN
    parameter int OP_WIDTH       = 2,
    parameter int TIMEOUT_CYCLES = 64
`else
    parameter int OP_WIDTH       = 2
`endif
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic [NUM_REQ*OP_WIDTH-1:0]    req_op_i,
    input  logic [NUM_REQ*KEY_WIDTH-1:0]   req_key_i,
    input  logic [NUM_REQ*VALUE_WIDTH-1:0] req_value_i,
    output logic [NUM_REQ-1:0]             rsp_valid_o,
    output logic                           rsp_hit_o,
    output logic                           rsp_err_o,
    output logic [VALUE_WIDTH-1:0]         rsp_value_o,
    output logic                           ctrl_valid_o,
    input  logic                           ctrl_ready_i,
    output logic [OP_WIDTH-1:0]            ctrl_op_o,
    output logic [KEY_WIDTH-1:0]           ctrl_key_o,
    output logic [VALUE_WIDTH-1:0]         ctrl_value_o,
    input  logic                           ctrl_done_i,
    input  logic                           ctrl_hit_i,
    input  logic [VALUE_WIDTH-1:0]         ctrl_value_i,
    output logic                           busy_o
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [OP_WIDTH-1:0] OP_NOP = '0;
    localparam logic [OP_WIDTH-1:0] OP_GET = OP_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] owner;
    logic [PTR_W-1:0] winner;
    logic             win_found;
    logic [OP_WIDTH-1:0] win_op;
    logic             timeout;

    // Explicit wrap so non-power-of-two requester counts rotate correctly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_REQ-1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        logic [PTR_W-1:0] idx;
        idx       = rr_ptr;
        winner    = '0;
        win_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_found && req_valid_i[idx]) begin
                winner    = idx;
                win_found = 1'b1;
            end
            idx = ptr_inc(idx);
        end
    end

    assign win_op = req_op_i[winner*OP_WIDTH +: OP_WIDTH];

    always_comb begin
        req_ready_o = '0;
        if (!rst && state == IDLE && win_found)
            req_ready_o[winner] = 1'b1;
    end

    always_comb begin
        rsp_valid_o = '0;
        if (state == RESP)
            rsp_valid_o[owner] = 1'b1;
    end

`ifdef CACHE_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;
    assign timeout = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            owner        <= '0;
            busy_o       <= 1'b0;
            ctrl_valid_o <= 1'b0;
            ctrl_op_o    <= '0;
            ctrl_key_o   <= '0;
            ctrl_value_o <= '0;
            rsp_hit_o    <= 1'b0;
            rsp_err_o    <= 1'b0;
            rsp_value_o  <= '0;
`ifdef CACHE_ARB_TIMEOUT_EN
            wait_cnt     <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (win_found) begin
                    owner        <= winner;
                    ctrl_op_o    <= win_op;
                    ctrl_key_o   <= req_key_i[winner*KEY_WIDTH +: KEY_WIDTH];
                    ctrl_value_o <= req_value_i[winner*VALUE_WIDTH +: VALUE_WIDTH];
                    busy_o       <= 1'b1;
                    // NOPs never reach the controller; answer them directly.
                    if (win_op == OP_NOP) begin
                        rsp_hit_o   <= 1'b0;
                        rsp_err_o   <= 1'b0;
                        rsp_value_o <= '0;
                        state       <= RESP;
                    end else begin
                        ctrl_valid_o <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: if (ctrl_ready_i) begin
                    ctrl_valid_o <= 1'b0;
                    state        <= WAIT;
`ifdef CACHE_ARB_TIMEOUT_EN
                    wait_cnt     <= '0;
`endif
                end
                WAIT: begin
                    if (ctrl_done_i) begin
                        rsp_hit_o   <= ctrl_hit_i;
                        rsp_err_o   <= 1'b0;
                        rsp_value_o <= (ctrl_op_o == OP_GET) ? ctrl_value_i : '0;
                        state       <= RESP;
                    end else if (timeout) begin
                        rsp_hit_o   <= 1'b0;
                        rsp_err_o   <= 1'b1;
                        rsp_value_o <= '0;
                        state       <= RESP;
                    end
`ifdef CACHE_ARB_TIMEOUT_EN
                    else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    rr_ptr <= ptr_inc(owner);
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_req_arbiter.sv
// Directed bench for cache_req_arbiter: table of full transactions plus reset,
// backpressure, reset-mid-op and (with CACHE_ARB_TIMEOUT_EN) timeout sequences.
module tb_cache_req_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid_i;
    logic [1:0]  req_ready_o;
    logic [3:0]  req_op_i;
    logic [31:0] req_key_i;
    logic [127:0] req_value_i;
    logic [1:0]  rsp_valid_o;
    logic        rsp_hit_o;
    logic        rsp_err_o;
    logic [63:0] rsp_value_o;
    logic        ctrl_valid_o;
    logic        ctrl_ready_i;
    logic [1:0]  ctrl_op_o;
    logic [15:0] ctrl_key_o;
    logic [63:0] ctrl_value_o;
    logic        ctrl_done_i;
    logic        ctrl_hit_i;
    logic [63:0] ctrl_value_i;
    logic        busy_o;

    int total = 0;
    int bad   = 0;

    cache_req_arbiter dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_op_i(req_op_i), .req_key_i(req_key_i), .req_value_i(req_value_i),
        .rsp_valid_o(rsp_valid_o), .rsp_hit_o(rsp_hit_o), .rsp_err_o(rsp_err_o),
        .rsp_value_o(rsp_value_o),
        .ctrl_valid_o(ctrl_valid_o), .ctrl_ready_i(ctrl_ready_i),
        .ctrl_op_o(ctrl_op_o), .ctrl_key_o(ctrl_key_o), .ctrl_value_o(ctrl_value_o),
        .ctrl_done_i(ctrl_done_i), .ctrl_hit_i(ctrl_hit_i), .ctrl_value_i(ctrl_value_i),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  op0, op1;
        logic [15:0] key0, key1;
        logic [63:0] wv0, wv1;
        logic        hit_in;
        logic [63:0] val_in;
        logic [1:0]  grant;
        logic [15:0] exp_key;
        logic [1:0]  exp_op;
        logic [63:0] exp_wv;
        logic        exp_hit;
        logic [63:0] exp_val;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_txn(input vec_t v);
        @(negedge clk);
        req_valid_i  = v.valid;
        req_op_i     = {v.op1, v.op0};
        req_key_i    = {v.key1, v.key0};
        req_value_i  = {v.wv1, v.wv0};
        ctrl_ready_i = 1'b1;
        #1;
        chk("idle_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("grant", 64'(req_ready_o), 64'(v.grant));
        @(negedge clk);
        req_valid_i = v.valid & ~v.grant;
        #1;
        chk("busy", 64'(busy_o), 64'd1);
        chk("ready_busy", 64'(req_ready_o), 64'd0);
        if (v.exp_op == 2'd0) begin
            chk("nop_ctrl_valid", 64'(ctrl_valid_o), 64'd0);
            chk("nop_rsp_valid", 64'(rsp_valid_o), 64'(v.grant));
            chk("nop_hit", 64'(rsp_hit_o), 64'd0);
            chk("nop_value", rsp_value_o, 64'd0);
        end else begin
            chk("ctrl_valid", 64'(ctrl_valid_o), 64'd1);
            chk("ctrl_op", 64'(ctrl_op_o), 64'(v.exp_op));
            chk("ctrl_key", 64'(ctrl_key_o), 64'(v.exp_key));
            chk("ctrl_value", ctrl_value_o, v.exp_wv);
            @(negedge clk);
            #1;
            chk("wait_ctrl_valid", 64'(ctrl_valid_o), 64'd0);
            chk("wait_rsp_valid", 64'(rsp_valid_o), 64'd0);
            ctrl_done_i  = 1'b1;
            ctrl_hit_i   = v.hit_in;
            ctrl_value_i = v.val_in;
            @(negedge clk);
            ctrl_done_i = 1'b0;
            #1;
            chk("rsp_valid", 64'(rsp_valid_o), 64'(v.grant));
            chk("rsp_hit", 64'(rsp_hit_o), 64'(v.exp_hit));
            chk("rsp_value", rsp_value_o, v.exp_val);
            chk("rsp_err", 64'(rsp_err_o), 64'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{2'b10, 2'd0, 2'd1, 16'h0000, 16'hBEEF, 64'h0,  64'h0,    1'b1, 64'h1234,
                    2'b10, 16'hBEEF, 2'd1, 64'h0,    1'b1, 64'h1234};
        vecs[1] = '{2'b11, 2'd1, 2'd2, 16'h0001, 16'h0002, 64'h11, 64'hCAFE, 1'b1, 64'hAAAA,
                    2'b01, 16'h0001, 2'd1, 64'h11,   1'b1, 64'hAAAA};
        vecs[2] = '{2'b11, 2'd1, 2'd2, 16'h0001, 16'h0002, 64'h11, 64'hCAFE, 1'b0, 64'h5555,
                    2'b10, 16'h0002, 2'd2, 64'hCAFE, 1'b0, 64'h0};
        vecs[3] = '{2'b11, 2'd3, 2'd1, 16'h0003, 16'h0004, 64'h22, 64'h33,   1'b1, 64'hFFFF,
                    2'b01, 16'h0003, 2'd3, 64'h22,   1'b1, 64'h0};
        vecs[4] = '{2'b11, 2'd3, 2'd1, 16'h0003, 16'h0004, 64'h22, 64'h33,   1'b1, 64'h77,
                    2'b10, 16'h0004, 2'd1, 64'h33,   1'b1, 64'h77};
        vecs[5] = '{2'b01, 2'd0, 2'd0, 16'h0005, 16'h0000, 64'h44, 64'h0,    1'b1, 64'h99,
                    2'b01, 16'h0005, 2'd0, 64'h44,   1'b0, 64'h0};
        vecs[6] = '{2'b01, 2'd1, 2'd0, 16'h0010, 16'h0000, 64'h0,  64'h0,    1'b1, 64'hDEADBEEF00000001,
                    2'b01, 16'h0010, 2'd1, 64'h0,    1'b1, 64'hDEADBEEF00000001};

        rst = 1'b1; req_valid_i = 2'b11; req_op_i = 4'b0101; req_key_i = '0; req_value_i = '0;
        ctrl_ready_i = 1'b1; ctrl_done_i = 1'b0; ctrl_hit_i = 1'b0; ctrl_value_i = '0;

        // reset held with both requesters valid
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_ready", 64'(req_ready_o), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("rst_ctrl_valid", 64'(ctrl_valid_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_rsp_value", rsp_value_o, 64'd0);
        chk("rst_ctrl_key", 64'(ctrl_key_o), 64'd0);
        rst = 1'b0;
        #1;
        chk("first_grant", 64'(req_ready_o), 64'd1);
        req_valid_i = 2'b00;

        foreach (vecs[i]) run_txn(vecs[i]);

        // backpressure in ISSUE, with a stray done that must be ignored
        @(negedge clk);
        req_valid_i = 2'b01; req_op_i = 4'b0001; req_key_i = {16'h0, 16'h1357};
        #1;
        chk("bp_grant", 64'(req_ready_o), 64'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            req_valid_i = 2'b11; ctrl_ready_i = 1'b0;
            ctrl_done_i = (c == 2); ctrl_hit_i = 1'b1; ctrl_value_i = 64'h999;
            #1;
            chk("bp_ctrl_valid", 64'(ctrl_valid_o), 64'd1);
            chk("bp_ctrl_key", 64'(ctrl_key_o), 64'h1357);
            chk("bp_ready", 64'(req_ready_o), 64'd0);
        end
        @(negedge clk);
        ctrl_done_i = 1'b0; ctrl_ready_i = 1'b1; req_valid_i = 2'b00;
        #1;
        chk("bp_release_valid", 64'(ctrl_valid_o), 64'd1);
        @(negedge clk);
        #1;
        chk("bp_wait_ctrl_valid", 64'(ctrl_valid_o), 64'd0);
        chk("bp_wait_rsp", 64'(rsp_valid_o), 64'd0);
        ctrl_done_i = 1'b1; ctrl_hit_i = 1'b0; ctrl_value_i = 64'h42;
        @(negedge clk);
        ctrl_done_i = 1'b0;
        #1;
        chk("bp_rsp_valid", 64'(rsp_valid_o), 64'd1);
        chk("bp_rsp_hit", 64'(rsp_hit_o), 64'd0);
        chk("bp_rsp_value", rsp_value_o, 64'h42);
        @(negedge clk);
        #1;
        chk("bp_rsp_pulse", 64'(rsp_valid_o), 64'd0);
        chk("bp_value_hold", rsp_value_o, 64'h42);
        chk("bp_idle_busy", 64'(busy_o), 64'd0);

        // PUT dropped by reset while in WAIT; rr_ptr is 1 here and must return to 0
        req_valid_i = 2'b10; req_op_i = 4'b1000; req_key_i = {16'h2468, 16'h0};
        req_value_i = {64'h5, 64'h0};
        #1;
        chk("rm_grant", 64'(req_ready_o), 64'd2);
        @(negedge clk);
        req_valid_i = 2'b00;
        #1;
        chk("rm_ctrl_valid", 64'(ctrl_valid_o), 64'd1);
        chk("rm_ctrl_op", 64'(ctrl_op_o), 64'd2);
        @(negedge clk);
        #1;
        chk("rm_wait_busy", 64'(busy_o), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rm_busy", 64'(busy_o), 64'd0);
        chk("rm_ctrl_valid0", 64'(ctrl_valid_o), 64'd0);
        chk("rm_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("rm_rsp_value", rsp_value_o, 64'd0);
        chk("rm_ctrl_key", 64'(ctrl_key_o), 64'd0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            chk("rm_no_rsp", 64'(rsp_valid_o), 64'd0);
        end
        req_valid_i = 2'b11;
        #1;
        chk("rm_rr_reset", 64'(req_ready_o), 64'd1);
        req_valid_i = 2'b00;

`ifdef CACHE_ARB_TIMEOUT_EN
        for (int pass = 0; pass < 2; pass++) begin
            int n;
            bit seen;
            n = 0; seen = 1'b0;
            @(negedge clk);
            req_valid_i = 2'b01; req_op_i = 4'b0001; req_key_i = {16'h0, 16'h00AA};
            #1;
            chk("to_grant", 64'(req_ready_o), 64'd1);
            @(negedge clk);
            req_valid_i = 2'b00;
            for (int c = 0; c < 100 && !seen; c++) begin
                @(negedge clk);
                ctrl_done_i = 1'b0;
                #1;
                if (rsp_valid_o != 2'b00) seen = 1'b1;
                else begin
                    if (pass == 1 && n == 63) begin
                        ctrl_done_i = 1'b1; ctrl_hit_i = 1'b1; ctrl_value_i = 64'h5A;
                    end
                    n++;
                end
            end
            ctrl_done_i = 1'b0;
            chk("to_seen", 64'(seen), 64'd1);
            chk("to_wait_cycles", 64'(n), 64'd64);
            chk("to_err", 64'(rsp_err_o), (pass == 0) ? 64'd1 : 64'd0);
            chk("to_hit", 64'(rsp_hit_o), (pass == 0) ? 64'd0 : 64'd1);
            chk("to_value", rsp_value_o, (pass == 0) ? 64'd0 : 64'h5A);
        end
`endif

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
